// File: rtl/tfifo_slots.sv
// Transparent elastic FIFO: an empty FIFO with a ready consumer passes the token
// through in the same cycle; otherwise tokens queue in a circular buffer of NUM_SLOTS.
module tfifo_slots #(
  parameter int DATA_TYPE = 32,
  parameter int NUM_SLOTS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_TYPE-1:0]           ins,
  input  logic                           ins_valid,
  output logic                           ins_ready,
  output logic [DATA_TYPE-1:0]           outs,
  output logic                           outs_valid,
  input  logic                           outs_ready,
  output logic [$clog2(NUM_SLOTS+1)-1:0] occupancy
);

  localparam int PW = $clog2(NUM_SLOTS);
  localparam int CW = $clog2(NUM_SLOTS + 1);

  // Handshake: a token moves on a side exactly when valid and ready are both high
  // in the same cycle; valid never depends on the ready of the same side.

  logic [DATA_TYPE-1:0] r_mem [NUM_SLOTS];
  logic [PW-1:0]        r_head;
  logic [PW-1:0]        r_tail;
  logic [CW-1:0]        r_count;

  logic          w_empty;
  logic          w_full;
  logic          w_in_xfer;
  logic          w_bypass;
  logic          w_wr;
  logic          w_rd;
  logic [PW-1:0] w_head_nxt;
  logic [PW-1:0] w_tail_nxt;
  logic [CW-1:0] w_count_nxt;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(NUM_SLOTS));

  // Both handshake outputs are forced low while in reset so nothing transfers.
  assign outs_valid = !rst && (ins_valid || !w_empty);
  assign ins_ready  = !rst && (!w_full || outs_ready);
  assign outs       = w_empty ? ins : r_mem[r_head];
  assign occupancy  = r_count;

  assign w_in_xfer = ins_valid && ins_ready;
  assign w_bypass  = w_empty && ins_valid && outs_ready;
  assign w_wr      = w_in_xfer && !w_bypass;
  assign w_rd      = !rst && outs_ready && !w_empty;

  // Explicit wrap compare keeps non-power-of-two depths correct.
  assign w_head_nxt = (r_head == PW'(NUM_SLOTS - 1)) ? '0 : r_head + PW'(1);
  assign w_tail_nxt = (r_tail == PW'(NUM_SLOTS - 1)) ? '0 : r_tail + PW'(1);

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !w_rd) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_wr && w_rd) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      // When full with a simultaneous read, tail equals head: the write lands in
      // the slot being freed, and outs already carried the old value this cycle.
      if (w_wr) begin
        r_mem[r_tail] <= ins;
        r_tail        <= w_tail_nxt;
      end
      if (w_rd) begin
        r_head <= w_head_nxt;
      end
      r_count <= w_count_nxt;
    end
  end

endmodule
